// File: rtl/weight_ram_ctrl_pkg.sv
// Shared sizing and state encoding for the weight RAM sequencer.
package weight_ram_ctrl_pkg;
  localparam int BIT_WIDTH  = 8;
  localparam int NR_DEPTH   = 8;
  localparam int DEPTH_BITS = 3;
  localparam int NR_FEATURE = 6;
  localparam int FEAT_BITS  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RD    = 3'd3,
    ST_RESP  = 3'd4
  } state_t;
endpackage

// File: rtl/weight_ram_ctrl_if.sv
// Stream, filter-request and RAM-port signals of the weight RAM sequencer.
interface weight_ram_ctrl_if;
  import weight_ram_ctrl_pkg::*;

  logic                  load_start;
  logic [BIT_WIDTH-1:0]  data_in;
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic                  load_done;
  logic                  loaded;
  logic                  filter_req;
  logic [DEPTH_BITS-1:0] filter_idx;
  logic                  filter_req_ready;
  logic                  weights_valid;
  logic                  weights_ack;
  logic                  ram_write_en;
  logic [DEPTH_BITS-1:0] ram_addr_depth_wr;
  logic [FEAT_BITS-1:0]  ram_addr_width_wr;
  logic [BIT_WIDTH-1:0]  ram_write_data;
  logic                  ram_read_en;
  logic [DEPTH_BITS-1:0] ram_addr_depth_rd;

  modport master (
    output load_start, data_in, data_in_valid, filter_req, filter_idx, weights_ack,
    input  data_in_ready, load_done, loaded, filter_req_ready, weights_valid,
           ram_write_en, ram_addr_depth_wr, ram_addr_width_wr, ram_write_data,
           ram_read_en, ram_addr_depth_rd
  );

  modport slave (
    input  load_start, data_in, data_in_valid, filter_req, filter_idx, weights_ack,
    output data_in_ready, load_done, loaded, filter_req_ready, weights_valid,
           ram_write_en, ram_addr_depth_wr, ram_addr_width_wr, ram_write_data,
           ram_read_en, ram_addr_depth_rd
  );
endinterface

// File: rtl/weight_ram_ctrl_addr_gen.sv
// Column-major (feature, filter) write-address counter for the weight load.
module weight_ram_ctrl_addr_gen
  import weight_ram_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  step,
  output logic [FEAT_BITS-1:0]  feat,
  output logic [DEPTH_BITS-1:0] filt,
  output logic                  last
);
  localparam logic [FEAT_BITS-1:0]  FEAT_MAX = FEAT_BITS'(NR_FEATURE - 1);
  localparam logic [DEPTH_BITS-1:0] FILT_MAX = DEPTH_BITS'(NR_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      feat <= '0;
      filt <= '0;
    end else if (step) begin
      if (feat == FEAT_MAX) begin
        feat <= '0;
        filt <= (filt == FILT_MAX) ? '0 : filt + 1'b1;
      end else begin
        feat <= feat + 1'b1;
      end
    end
  end

  assign last = (feat == FEAT_MAX) && (filt == FILT_MAX);
endmodule

// File: rtl/weight_ram_ctrl.sv
// Weight RAM sequencer: serial load into the RAM, then per-filter reads for the conv engine.
//   state    | meaning
//   ST_IDLE  | no weight set; waiting for load_start
//   ST_LOAD  | accepting stream words, one RAM write per valid beat
//   ST_READY | weights loaded; accepting filter requests
//   ST_RD    | single-cycle RAM read of the latched filter
//   ST_RESP  | weights_valid held until weights_ack
module weight_ram_ctrl
  import weight_ram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  weight_ram_ctrl_if.slave   bus
);
  state_t                state_q, state_d;
  logic [DEPTH_BITS-1:0] req_idx_q;
  logic [DEPTH_BITS-1:0] wr_depth_hold_q, rd_depth_hold_q;
  logic [FEAT_BITS-1:0]  wr_width_hold_q;
  logic                  loaded_q, load_done_q;
  logic                  clear, step, latch, done_d;
  logic                  write_en, read_en;
  logic                  in_ready, req_ready, w_valid;
  logic                  last;
  logic                  idx_ok;
  logic [FEAT_BITS-1:0]  feat;
  logic [DEPTH_BITS-1:0] filt;

  weight_ram_ctrl_addr_gen u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .step  (step),
    .feat  (feat),
    .filt  (filt),
    .last  (last)
  );

  // Out-of-range indices only exist when NR_DEPTH is not a power of two.
  assign idx_ok = (32'(bus.filter_idx) < NR_DEPTH);

  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    step      = 1'b0;
    latch     = 1'b0;
    done_d    = 1'b0;
    write_en  = 1'b0;
    read_en   = 1'b0;
    in_ready  = 1'b0;
    req_ready = 1'b0;
    w_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_start) begin
          state_d = ST_LOAD;
          clear   = 1'b1;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (bus.load_start) begin
          clear = 1'b1;
        end else if (bus.data_in_valid) begin
          write_en = 1'b1;
          step     = 1'b1;
          if (last) begin
            state_d = ST_READY;
            done_d  = 1'b1;
          end
        end
      end
      ST_READY: begin
        if (bus.load_start) begin
          state_d = ST_LOAD;
          clear   = 1'b1;
        end else begin
          req_ready = 1'b1;
          if (bus.filter_req && idx_ok) begin
            latch   = 1'b1;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        read_en = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        w_valid = 1'b1;
        if (bus.weights_ack) state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      req_idx_q       <= '0;
      wr_depth_hold_q <= '0;
      wr_width_hold_q <= '0;
      rd_depth_hold_q <= '0;
      loaded_q        <= 1'b0;
      load_done_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done_q <= done_d;
      if (done_d)     loaded_q  <= 1'b1;
      else if (clear) loaded_q  <= 1'b0;
      if (latch)      req_idx_q <= bus.filter_idx;
      if (write_en) begin
        wr_depth_hold_q <= filt;
        wr_width_hold_q <= feat;
      end
      if (read_en)    rd_depth_hold_q <= req_idx_q;
    end
  end

  // RAM addresses follow the live source only while the matching enable is high.
  assign bus.ram_write_en      = write_en;
  assign bus.ram_write_data    = bus.data_in;
  assign bus.ram_addr_depth_wr = write_en ? filt : wr_depth_hold_q;
  assign bus.ram_addr_width_wr = write_en ? feat : wr_width_hold_q;
  assign bus.ram_read_en       = read_en;
  assign bus.ram_addr_depth_rd = read_en ? req_idx_q : rd_depth_hold_q;
  assign bus.data_in_ready     = in_ready;
  assign bus.filter_req_ready  = req_ready;
  assign bus.weights_valid     = w_valid;
  assign bus.load_done         = load_done_q;
  assign bus.loaded            = loaded_q;
endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Bench for weight_ram_ctrl with a negedge-timed behavioural weight RAM alongside.
module tb_weight_ram_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;

  weight_ram_ctrl_if bus ();
  weight_ram_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] mem   [8][6];
  logic [7:0] rdata [6];
  int         wr_log [$];

  always @(negedge clk) begin
    if (bus.ram_write_en) begin
      mem[bus.ram_addr_depth_wr][bus.ram_addr_width_wr] <= bus.ram_write_data;
      wr_log.push_back(int'(bus.ram_addr_depth_wr) * 6 + int'(bus.ram_addr_width_wr));
    end
    if (bus.ram_read_en)
      for (int i = 0; i < 6; i++) rdata[i] <= mem[bus.ram_addr_depth_rd][i];
  end

  typedef struct {
    int idx;
    int hold;
    int base;
  } rd_vec_t;

  rd_vec_t vecs [4];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int all_outs();
    return int'({bus.data_in_ready, bus.load_done, bus.loaded, bus.filter_req_ready,
                 bus.weights_valid, bus.ram_write_en, bus.ram_addr_depth_wr,
                 bus.ram_addr_width_wr, bus.ram_read_en, bus.ram_addr_depth_rd});
  endfunction

  // Streams 48 words base..base+47 from inside LOAD, then checks completion.
  task automatic stream(input int base, input bit toggle);
    int k = 0;
    int cyc = 0;
    int log0;
    int bad = 0;
    int seen [48];
    log0 = wr_log.size();
    while (k < 48 && cyc < 200) begin
      bus.data_in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.data_in       = 8'(base + k);
      #1;
      if (bus.data_in_valid) begin
        chk("wr_width", int'(bus.ram_addr_width_wr), k % 6);
        chk("wr_depth", int'(bus.ram_addr_depth_wr), k / 6);
        k++;
      end else begin
        chk("no_write_when_invalid", int'(bus.ram_write_en), 0);
      end
      tick();
      cyc++;
    end
    bus.data_in_valid = 1'b0;
    chk("load_beats", k, 48);
    chk("load_done_pulse", int'(bus.load_done), 1);
    chk("loaded_set", int'(bus.loaded), 1);
    chk("write_count", wr_log.size() - log0, 48);
    for (int a = 0; a < 48; a++) seen[a] = 0;
    for (int j = log0; j < wr_log.size(); j++)
      if (wr_log[j] >= 0 && wr_log[j] < 48) seen[wr_log[j]]++;
    for (int a = 0; a < 48; a++) if (seen[a] != 1) bad++;
    chk("addr_once_each", bad, 0);
    bad = 0;
    for (int d = 0; d < 8; d++)
      for (int w = 0; w < 6; w++)
        if (mem[d][w] !== 8'(base + 6 * d + w)) bad++;
    chk("ram_contents", bad, 0);
    tick();
    chk("load_done_single", int'(bus.load_done), 0);
    chk("loaded_held", int'(bus.loaded), 1);
  endtask

  task automatic do_load(input int base, input bit toggle);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    stream(base, toggle);
  endtask

  task automatic do_read(input int idx, input int base, input int hold);
    bus.filter_req = 1'b1;
    bus.filter_idx = 3'(idx);
    #1;
    chk("req_ready", int'(bus.filter_req_ready), 1);
    tick();
    bus.filter_req = 1'b0;
    chk("rd_en", int'(bus.ram_read_en), 1);
    chk("rd_addr", int'(bus.ram_addr_depth_rd), idx);
    chk("valid_early", int'(bus.weights_valid), 0);
    tick();
    for (int h = 0; h <= hold; h++) begin
      chk("weights_valid", int'(bus.weights_valid), 1);
      chk("rd_en_low_resp", int'(bus.ram_read_en), 0);
      for (int i = 0; i < 6; i++) chk("weight_word", int'(rdata[i]), base + i);
      if (h == hold) bus.weights_ack = 1'b1;
      tick();
    end
    bus.weights_ack = 1'b0;
    chk("valid_drop", int'(bus.weights_valid), 0);
    chk("back_ready", int'(bus.filter_req_ready), 1);
  endtask

  initial begin
    vecs[0] = '{idx: 5, hold: 2, base: 30};
    vecs[1] = '{idx: 0, hold: 0, base: 0};
    vecs[2] = '{idx: 7, hold: 1, base: 42};
    vecs[3] = '{idx: 3, hold: 0, base: 18};

    reset = 1'b1;
    bus.load_start = 1'b0;  bus.data_in = '0;     bus.data_in_valid = 1'b0;
    bus.filter_req = 1'b0;  bus.filter_idx = '0;  bus.weights_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_outs", all_outs(), 0);
    bus.filter_req = 1'b1;
    tick();
    chk("idle_ignores_req", int'(bus.ram_read_en), 0);
    chk("idle_req_ready", int'(bus.filter_req_ready), 0);
    bus.filter_req = 1'b0;

    // Straight load, then table-driven reads.
    do_load(0, 1'b0);
    foreach (vecs[v]) do_read(vecs[v].idx, vecs[v].base, vecs[v].hold);

    // Valid toggling every cycle.
    do_load(200, 1'b1);
    do_read(2, 212, 0);

    // Restart after 20 beats, then full reload.
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    chk("loaded_low_reload", int'(bus.loaded), 0);
    for (int k = 0; k < 20; k++) begin
      bus.data_in_valid = 1'b1;
      bus.data_in = 8'(50 + k);
      tick();
    end
    bus.load_start = 1'b1;
    bus.data_in = 8'd99;
    #1;
    chk("restart_no_write", int'(bus.ram_write_en), 0);
    chk("loaded_low_partial", int'(bus.loaded), 0);
    tick();
    bus.load_start = 1'b0;
    stream(100, 1'b0);
    do_read(0, 100, 0);

    // Load_start wins over Filter_req in READY.
    bus.load_start = 1'b1;
    bus.filter_req = 1'b1;
    bus.filter_idx = 3'd2;
    #1;
    chk("prio_req_ready", int'(bus.filter_req_ready), 0);
    tick();
    bus.load_start = 1'b0;
    bus.filter_req = 1'b0;
    chk("prio_in_load", int'(bus.data_in_ready), 1);
    chk("prio_no_read", int'(bus.ram_read_en), 0);
    chk("prio_loaded_low", int'(bus.loaded), 0);
    stream(100, 1'b0);

    // Reset while in RESP.
    bus.filter_req = 1'b1;
    bus.filter_idx = 3'd1;
    tick();
    bus.filter_req = 1'b0;
    tick();
    chk("resp_before_reset", int'(bus.weights_valid), 1);
    reset = 1'b1;
    bus.data_in = '0;
    tick();
    reset = 1'b0;
    chk("reset_in_resp", all_outs(), 0);
    bus.filter_req = 1'b1;
    #1;
    chk("post_reset_req_ready", int'(bus.filter_req_ready), 0);
    tick();
    bus.filter_req = 1'b0;
    chk("post_reset_no_read", int'(bus.ram_read_en), 0);

    // Reset mid-load: stream without a new load_start must not write.
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.data_in_valid = 1'b1;
      bus.data_in = 8'(k);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    #1;
    chk("reset_in_load", all_outs(), 0);
    begin
      int log0;
      log0 = wr_log.size();
      bus.data_in_valid = 1'b1;
      bus.data_in = 8'd77;
      #1;
      chk("idle_no_write_en", int'(bus.ram_write_en), 0);
      tick(); tick(); tick();
      bus.data_in_valid = 1'b0;
      chk("idle_no_writes", wr_log.size() - log0, 0);
      chk("idle_not_loaded", int'(bus.loaded), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
